// File: rtl/rand_sched_pkg.sv
// rand_sched_pkg: shared types and constants for the random-byte scheduler.
//   state_e   - controller FSM states (SEED, WARMUP, RUN)
//   RAND_W    - width of the generator byte
//   SEED_RST  - seed register value out of reset
package rand_sched_pkg;

   localparam int RAND_W = 8;
   localparam logic [RAND_W-1:0] SEED_RST = 8'hFF;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } state_e;

endpackage

// File: rtl/rand_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req_i - request vector
//   en_i  - when low, no winner is produced
//   ptr_i - index of the previous winner; search starts at ptr_i+1 and wraps
//   gnt_o - one-hot winner (zero if none)
//   idx_o - index of the winner (zero if none)
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic                       en_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o
);

   localparam int PW = $clog2(NUM_REQ);

   logic          found;
   logic [PW-1:0] idx;

   // Offsets 1..NUM_REQ from the pointer; the last offset revisits the
   // previous winner so a lone requester keeps winning every cycle.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = PW'((int'(ptr_i) + i) % NUM_REQ);
         if (en_i && !found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            idx_o      = idx;
         end
      end
   end

endmodule

// File: rtl/rand_sched.sv
// rand_sched: owns the seed port of the shared rand_gen, sequences
// reseed + warm-up, then hands out one distinct generator byte per grant
// to NUM_REQ requesters in round-robin order.
//   clk, rst            - clock, synchronous active-high reset
//   seed_i, seed_load_i - reseed value and request
//   busy_o              - high in SEED or WARMUP
//   req_i, gnt_o        - level requests, registered one-hot grant
//   rand_o              - byte delivered with the grant
//   rng_seed_o, rng_set_seed_o, rng_rand_i - rand_gen hookup
//   grant_cnt_o         - saturating grant count (only with RAND_SCHED_STATS_EN)
// Optional feature macro: RAND_SCHED_STATS_EN
module rand_sched
   import rand_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WARMUP  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [RAND_W-1:0]  seed_i,
   input  logic               seed_load_i,
   output logic               busy_o,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [RAND_W-1:0]  rand_o,
   output logic [RAND_W-1:0]  rng_seed_o,
   output logic               rng_set_seed_o,
`ifdef RAND_SCHED_STATS_EN
   output logic [15:0]        grant_cnt_o,
`endif
   input  logic [RAND_W-1:0]  rng_rand_i
);

   localparam int PW = $clog2(NUM_REQ);

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [RAND_W-1:0]   seed_q, seed_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [RAND_W-1:0]   rand_q, rand_d;

   logic                arb_en;
   logic [NUM_REQ-1:0]  win_oh;
   logic [PW-1:0]       win_idx;
   logic                win_any;

   // A reseed request in the same cycle pre-empts any grant.
   assign arb_en  = (state_q == ST_RUN) && !seed_load_i;
   assign win_any = |win_oh;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i (req_i),
      .en_i  (arb_en),
      .ptr_i (ptr_q),
      .gnt_o (win_oh),
      .idx_o (win_idx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seed_d  = seed_q;
      if (seed_load_i) begin
         // Restart from SEED even when already seeding or warming up.
         state_d = ST_SEED;
         seed_d  = seed_i;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_SEED: begin
               state_d = ST_WARMUP;
               cnt_d   = '0;
            end
            ST_WARMUP: begin
               if (cnt_q == 8'(WARMUP - 1)) state_d = ST_RUN;
               else                         cnt_d   = cnt_q + 8'd1;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_WARMUP;
         endcase
      end
   end

   always_comb begin
      gnt_d  = win_oh;
      rand_d = win_any ? rng_rand_i : rand_q;
      ptr_d  = win_any ? win_idx    : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // rand_gen resets alongside us, so go straight to WARMUP.
         state_q <= ST_WARMUP;
         cnt_q   <= '0;
         seed_q  <= SEED_RST;
         ptr_q   <= PW'(NUM_REQ - 1);
         gnt_q   <= '0;
         rand_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seed_q  <= seed_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         rand_q  <= rand_d;
      end
   end

   assign busy_o         = (state_q != ST_RUN);
   assign gnt_o          = gnt_q;
   assign rand_o         = rand_q;
   assign rng_seed_o     = seed_q;
   assign rng_set_seed_o = (state_q == ST_SEED);

`ifdef RAND_SCHED_STATS_EN
   logic [15:0] gcnt_q;

   always_ff @(posedge clk) begin
      if (rst || seed_load_i)                gcnt_q <= '0;
      else if (win_any && gcnt_q != 16'hFFFF) gcnt_q <= gcnt_q + 16'd1;
   end

   assign grant_cnt_o = gcnt_q;
`endif

endmodule

// File: tb/tb_rand_sched.sv
// tb_rand_sched: directed checks of reset, warm-up length, round-robin order,
// byte delivery, reseed sequencing and reset during SEED. A small LFSR stands
// in for rand_gen (zero seed locks it at zero).
module tb_rand_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] seed_i;
   logic       seed_load_i;
   logic       busy_o;
   logic [3:0] req_i;
   logic [3:0] gnt_o;
   logic [7:0] rand_o;
   logic [7:0] rng_seed_o;
   logic       rng_set_seed_o;
   logic [7:0] g;
`ifdef RAND_SCHED_STATS_EN
   logic [15:0] grant_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rand_sched #(.NUM_REQ(4), .WARMUP(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .seed_i         (seed_i),
      .seed_load_i    (seed_load_i),
      .busy_o         (busy_o),
      .req_i          (req_i),
      .gnt_o          (gnt_o),
      .rand_o         (rand_o),
      .rng_seed_o     (rng_seed_o),
      .rng_set_seed_o (rng_set_seed_o),
`ifdef RAND_SCHED_STATS_EN
      .grant_cnt_o    (grant_cnt_o),
`endif
      .rng_rand_i     (g)
   );

   // Generator stand-in: Galois LFSR, reset value FF, loads on set_seed.
   always @(posedge clk) begin
      if (rst)                 g <= 8'hFF;
      else if (rng_set_seed_o) g <= rng_seed_o;
      else                     g <= {g[6:0], 1'b0} ^ (g[7] ? 8'h1D : 8'h00);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts busy cycles starting with the current one; bounded.
   task automatic wait_busy(output int n, output int ns);
      n = 0;
      ns = 0;
      while (busy_o && n < 100) begin
         n++;
         if (rng_set_seed_o) ns++;
         step();
      end
   endtask

   int n, ns;
   logic [7:0] e;

   initial begin
      rst = 1'b1; req_i = '0; seed_load_i = 1'b0; seed_i = '0;
      @(negedge clk);
      repeat (2) step();

      // reset state
      chk("rst_busy", 32'(busy_o), 1);
      chk("rst_gnt", 32'(gnt_o), 0);
      chk("rst_rand", 32'(rand_o), 0);
      chk("rst_seed", 32'(rng_seed_o), 32'hFF);
      chk("rst_setseed", 32'(rng_set_seed_o), 0);

      // warm-up after reset, single requester
      req_i = 4'b0001; rst = 1'b0;
      wait_busy(n, ns);
      chk("wu_len", n, 8);
      chk("wu_gnt0", 32'(gnt_o), 0);
      for (int k = 0; k < 3; k++) begin
         e = g; step();
         chk("r0_gnt", 32'(gnt_o), 32'h1);
         chk("r0_rand", 32'(rand_o), 32'(e));
      end

      // all requesting: rotation from requester 1 (pointer at 0)
      req_i = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         e = g; step();
         chk("rr_gnt", 32'(gnt_o), 32'(1 << ((k + 1) % 4)));
         chk("rr_rand", 32'(rand_o), 32'(e));
      end
`ifdef RAND_SCHED_STATS_EN
      chk("st_cnt11", 32'(grant_cnt_o), 11);
`endif

      // reseed with zero while requests are active
      seed_i = 8'h00; seed_load_i = 1'b1;
      step();
      seed_load_i = 1'b0;
      chk("rs_nognt", 32'(gnt_o), 0);
      chk("rs_set", 32'(rng_set_seed_o), 1);
      chk("rs_seed", 32'(rng_seed_o), 0);
      wait_busy(n, ns);
      chk("rs_len", n, 9);
      chk("rs_setcnt", ns, 1);
      chk("rs_gnt0", 32'(gnt_o), 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("z_gnt", 32'(gnt_o), 32'(1 << ((k + 1) % 4)));
         chk("z_rand", 32'(rand_o), 0);
      end
`ifdef RAND_SCHED_STATS_EN
      chk("st_cnt4", 32'(grant_cnt_o), 4);
`endif

      // reseed again in the middle of WARMUP
      seed_i = 8'h5A; seed_load_i = 1'b1;
      step();
      seed_load_i = 1'b0;
      step(); step();
      seed_i = 8'hA5; seed_load_i = 1'b1;
      step();
      seed_load_i = 1'b0;
      chk("mw_set", 32'(rng_set_seed_o), 1);
      chk("mw_seed", 32'(rng_seed_o), 32'hA5);
      wait_busy(n, ns);
      chk("mw_len", n, 9);
      chk("mw_setcnt", ns, 1);
      chk("mw_gnt0", 32'(gnt_o), 0);
      e = g; step();
      chk("mw_gnt", 32'(gnt_o), 32'h2);
      chk("mw_rand", 32'(rand_o), 32'(e));

      // reset while in SEED
      seed_i = 8'h3C; seed_load_i = 1'b1;
      step();
      seed_load_i = 1'b0;
      chk("rsd_set1", 32'(rng_set_seed_o), 1);
      rst = 1'b1;
      step();
      chk("rsd_set0", 32'(rng_set_seed_o), 0);
      chk("rsd_gnt", 32'(gnt_o), 0);
      chk("rsd_busy", 32'(busy_o), 1);
      chk("rsd_seed", 32'(rng_seed_o), 32'hFF);
      rst = 1'b0;
      wait_busy(n, ns);
      chk("rsd_len", n, 8);
      chk("rsd_setcnt", ns, 0);
      e = g; step();
      chk("rsd_gnt0", 32'(gnt_o), 32'h1);
      chk("rsd_rand", 32'(rand_o), 32'(e));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
